// File: rtl/mc14500b_sequencer.sv
// mc14500b_sequencer
//   Program sequencer for the MC14500B ICU. It holds the program counter,
//   addresses the program ROM and presents the fetched word to the core. It
//   also reacts to the core's JMP/RTN/FLG0/FLGF flags: jumps, calls through a
//   hardware return stack, returns, and halt on NOPF.
//
//   Optional feature: MC14500B_SEQ_HALT_EN
//     defined   - FLGF enters HALT; a run pulse resumes.
//     undefined - FLGF is treated as a plain instruction; never halts.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   run             leave HALT on the following edge
//   rom_addr        ROM address (== pc)
//   rom_data        ROM word: [3:0] opcode, [PC_W+3:4] operand
//   instr, operand  fetched opcode / operand forwarded to the ICU
//   icu_en          ICU clock enable (0 while halted)
//   jmp, rtn,       ICU flag outputs for the current instruction
//   flg0, flgf
//   pc              program counter
//   depth           return-stack occupancy, 0..DEPTH
//   halted          1 while in HALT
//   stack_err       sticky stack overflow/underflow flag

module mc14500b_sequencer #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic [PC_W-1:0]  rom_addr,
    input  logic [PC_W+3:0]  rom_data,
    output logic [3:0]       instr,
    output logic [PC_W-1:0]  operand,
    output logic             icu_en,
    input  logic             jmp,
    input  logic             rtn,
    input  logic             flg0,
    input  logic             flgf,
    output logic [PC_W-1:0]  pc,
    output logic [4:0]       depth,
    output logic             halted,
    output logic             stack_err
);

    localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);

    logic [PC_W-1:0]  pc_q, pc_d, pc_inc;
    logic [4:0]       depth_q, depth_d;
    logic             arm_q, arm_d;
    logic             err_q, err_d;
    logic             push_en;
    logic [IDX_W-1:0] push_idx, pop_idx;
    logic [PC_W-1:0]  stack_q [DEPTH];

`ifdef MC14500B_SEQ_HALT_EN
    typedef enum logic {S_RUN, S_HALT} state_t;
    state_t state_q, state_d;
`else
    logic unused_inputs;
    assign unused_inputs = run ^ flgf;
`endif

    assign instr    = rom_data[3:0];
    assign operand  = rom_data[PC_W+3:4];
    assign rom_addr = pc_q;
    assign pc       = pc_q;
    assign depth    = depth_q;
    assign stack_err = err_q;
    assign pc_inc   = pc_q + PC_W'(1);
    // Push lands in the first free slot; pop reads the top entry.
    assign push_idx = depth_q[IDX_W-1:0];
    assign pop_idx  = IDX_W'(depth_q - 5'd1);

`ifdef MC14500B_SEQ_HALT_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif
    assign icu_en = ~halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            depth_q <= '0;
            arm_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef MC14500B_SEQ_HALT_EN
            state_q <= S_RUN;
`endif
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            arm_q   <= arm_d;
            err_q   <= err_d;
`ifdef MC14500B_SEQ_HALT_EN
            state_q <= state_d;
`endif
        end
    end

    // Stack storage needs no reset: depth alone defines the valid entries.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        arm_d   = arm_q;
        err_d   = err_q;
        push_en = 1'b0;
`ifdef MC14500B_SEQ_HALT_EN
        state_d = state_q;
        // HALT and FLGF head the priority chain; the else below joins the
        // flag chain that is shared with the build without halt support.
        if (state_q == S_HALT) begin
            if (run) begin
                state_d = S_RUN;
            end
        end else if (flgf) begin
            pc_d    = pc_inc;
            arm_d   = 1'b0;
            state_d = S_HALT;
        end else
`endif
        if (jmp) begin
            pc_d = operand;
            // A NOPO directly before this JMP makes it a call.
            if (arm_q) begin
                if (depth_q < DEPTH_L) begin
                    push_en = 1'b1;
                    depth_d = depth_q + 5'd1;
                end else begin
                    err_d = 1'b1;
                end
            end
            arm_d = 1'b0;
        end else if (rtn) begin
            if (depth_q != 5'd0) begin
                pc_d    = stack_q[pop_idx];
                depth_d = depth_q - 5'd1;
            end else begin
                pc_d  = '0;
                err_d = 1'b1;
            end
            arm_d = 1'b0;
        end else if (flg0) begin
            pc_d  = pc_inc;
            arm_d = 1'b1;
        end else begin
            pc_d  = pc_inc;
            arm_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc14500b_sequencer.sv
// Scoreboard bench for mc14500b_sequencer (PC_W=8, DEPTH=4). The bench acts
// as ROM and ICU; a queue-based reference model predicts each cycle's state.
module tb_mc14500b_sequencer;

    localparam int PC_W = 8;
    localparam int DEPTH = 4;
`ifdef MC14500B_SEQ_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    localparam logic [3:0] OP_NOPO = 4'h0, OP_LD = 4'h1, OP_JMP = 4'hC,
                           OP_RTN = 4'hD, OP_NOPF = 4'hF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic run = 1'b0;
    logic [PC_W-1:0] rom_addr, operand, pc;
    logic [PC_W+3:0] rom_data;
    logic [3:0] instr;
    logic icu_en, jmp, rtn, flg0, flgf, halted, stack_err;
    logic [4:0] depth;

    logic [11:0] rom [256];

    // Bench plays the ICU: flags decode straight from the fetched opcode.
    assign rom_data = rom[rom_addr];
    assign jmp  = (rom_data[3:0] == OP_JMP);
    assign rtn  = (rom_data[3:0] == OP_RTN);
    assign flg0 = (rom_data[3:0] == OP_NOPO);
    assign flgf = (rom_data[3:0] == OP_NOPF);

    mc14500b_sequencer #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .run(run), .rom_addr(rom_addr),
        .rom_data(rom_data), .instr(instr), .operand(operand),
        .icu_en(icu_en), .jmp(jmp), .rtn(rtn), .flg0(flg0), .flgf(flgf),
        .pc(pc), .depth(depth), .halted(halted), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        logic [4:0] depth;
        logic       halted;
        logic       err;
        logic [3:0] instr;
        logic [7:0] operand;
    } exp_t;

    exp_t sbq[$];
    event sample_ev;
    int n_checks = 0;
    int n_err = 0;

    // Reference model: stack is a plain queue, depth is its size.
    int m_pc;
    int m_stk[$];
    bit m_arm, m_halt, m_err;

    always @(posedge clk or posedge rst) begin
        exp_t e;
        logic [3:0] op;
        int opnd;
        if (rst) begin
            m_pc = 0; m_stk.delete(); m_arm = 0; m_halt = 0; m_err = 0;
        end else begin
            op   = rom[m_pc][3:0];
            opnd = int'(rom[m_pc][11:4]);
            if (m_halt) begin
                if (run) m_halt = 0;
            end else if (HALT_EN && op == OP_NOPF) begin
                m_pc = (m_pc + 1) % 256; m_halt = 1; m_arm = 0;
            end else if (op == OP_JMP) begin
                if (m_arm) begin
                    if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % 256);
                    else m_err = 1;
                end
                m_pc = opnd; m_arm = 0;
            end else if (op == OP_RTN) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_pc = 0; m_err = 1; end
                m_arm = 0;
            end else if (op == OP_NOPO) begin
                m_pc = (m_pc + 1) % 256; m_arm = 1;
            end else begin
                m_pc = (m_pc + 1) % 256; m_arm = 0;
            end
        end
        e.pc = 8'(m_pc); e.depth = 5'(m_stk.size()); e.halted = m_halt;
        e.err = m_err; e.instr = rom[m_pc][3:0]; e.operand = rom[m_pc][11:4];
        sbq.push_back(e);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: one expected record per clock edge or reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sample_ev);
            if (sbq.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL sb_empty at %0t: got 0 records expected 1", $time);
            end else begin
                e = sbq.pop_front();
                chk("pc", 32'(pc), 32'(e.pc));
                chk("rom_addr", 32'(rom_addr), 32'(e.pc));
                chk("depth", 32'(depth), 32'(e.depth));
                chk("halted", 32'(halted), 32'(e.halted));
                chk("icu_en", 32'(icu_en), 32'(!e.halted));
                chk("stack_err", 32'(stack_err), 32'(e.err));
                chk("instr", 32'(instr), 32'(e.instr));
                chk("operand", 32'(operand), 32'(e.operand));
            end
        end
    end

    function automatic logic [11:0] w(input logic [3:0] op, input int opnd);
        return {8'(opnd), op};
    endfunction

    task automatic load_prog(input int kind);
        int r;
        for (int i = 0; i < 256; i++) rom[i] = w(OP_LD, $urandom_range(0, 255));
        case (kind)
            1: begin // jump, call/return, halt, nested overflow, unwind
                rom[8'h03] = w(OP_JMP, 8'h40);
                rom[8'h40] = w(OP_JMP, 8'h10);
                rom[8'h10] = w(OP_NOPO, 0);
                rom[8'h11] = w(OP_JMP, 8'h80);
                rom[8'h85] = w(OP_RTN, 0);
                rom[8'h20] = w(OP_NOPF, 0);
                rom[8'h30] = w(OP_NOPO, 0); rom[8'h31] = w(OP_JMP, 8'h90);
                rom[8'h90] = w(OP_NOPO, 0); rom[8'h91] = w(OP_JMP, 8'hA0);
                rom[8'hA0] = w(OP_NOPO, 0); rom[8'hA1] = w(OP_JMP, 8'hB0);
                rom[8'hB0] = w(OP_NOPO, 0); rom[8'hB1] = w(OP_JMP, 8'hC0);
                rom[8'hC0] = w(OP_NOPO, 0); rom[8'hC1] = w(OP_JMP, 8'hD0);
                rom[8'hD8] = w(OP_RTN, 0);  rom[8'hB2] = w(OP_RTN, 0);
                rom[8'hA2] = w(OP_RTN, 0);  rom[8'h92] = w(OP_RTN, 0);
                rom[8'h32] = w(OP_RTN, 0);
            end
            2: rom[0] = w(OP_RTN, 0);
            3: begin
                rom[8'h00] = w(OP_NOPO, 0); rom[8'h01] = w(OP_JMP, 8'h40);
                rom[8'h40] = w(OP_NOPO, 0); rom[8'h41] = w(OP_JMP, 8'h80);
            end
            4: for (int i = 0; i < 256; i++) begin
                r = $urandom_range(0, 99);
                if (r < 4)       rom[i] = w(OP_NOPF, $urandom_range(0, 255));
                else if (r < 16) rom[i] = w(OP_JMP, $urandom_range(0, 255));
                else if (r < 24) rom[i] = w(OP_RTN, $urandom_range(0, 255));
                else if (r < 38) rom[i] = w(OP_NOPO, $urandom_range(0, 255));
                else rom[i] = w(4'($urandom_range(1, 11)), $urandom_range(0, 255));
            end
            default: ;
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset(input int kind);
        rst = 1'b1;
        #1 -> sample_ev;
        #1 load_prog(kind);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_model(input string nm, input int tgt_pc, input int tgt_halt, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (m_pc == tgt_pc && int'(m_halt) == tgt_halt) break;
            step();
        end
        n_checks++;
        if (i == budget) begin
            n_err++;
            $display("FAIL %s: got timeout expected pc %0h reached", nm, tgt_pc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        load_prog(0);
        #1;
        do_reset(0);
        // Linear fetch with wrap past 255.
        repeat (262) step();

        do_reset(1);
        wait_model("reach_halt_pc", 8'h21, HALT_EN ? 1 : 0, 60);
`ifdef MC14500B_SEQ_HALT_EN
        repeat (10) step();
        run = 1'b1; step(); run = 1'b0;
`endif
        repeat (160) step();

        // Return at depth 0 right after reset.
        do_reset(2);
        repeat (6) step();

        // Reset pulse between edges in the middle of a nested call.
        do_reset(3);
        wait_model("reach_0x85", 8'h85, 0, 40);
        rst = 1'b1;
        #1 -> sample_ev;
        #1 rst = 1'b0;
        repeat (8) step();

        for (int k = 0; k < 5; k++) begin
            do_reset(4);
            for (int c = 0; c < 300; c++) begin
                run = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 249) == 0) begin
                    rst = 1'b1;
                    #1 -> sample_ev;
                    #1 rst = 1'b0;
                end
                step();
            end
            run = 1'b0;
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mc14500b_sequencer.md
Name: mc14500b_sequencer

Overview:
- Program sequencer for the MC14500B ICU: the memory-side counterpart that feeds instructions to the core and reacts to its JMP/RTN/FLG0/FLGF flag outputs.
- Holds the program counter and addresses the program ROM.
- Provides a hardware return stack for subroutine calls and halts on FLGF.
- Sits between the program ROM and the MC14500B core; one instance per ICU.

Parameters:
- PC_W, 8, program counter and operand width in bits; ROM depth is 2^PC_W words.
- DEPTH, 4, return-stack entries, 1..16.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  one-cycle pulse; leaves HALT.
- rom_addr  out  PC_W  ROM address; equals pc.
- rom_data  in  4+PC_W  ROM word, combinational read of rom_addr; [3:0] opcode, [PC_W+3:4] operand.
- instr  out  4  opcode to ICU, rom_data[3:0].
- operand  out  PC_W  operand to ICU (I/O select / jump target), rom_data[PC_W+3:4].
- icu_en  out  1  ICU clock enable; 1 in RUN, 0 in HALT.
- jmp  in  1  ICU JMP flag for current instruction.
- rtn  in  1  ICU RTN flag for current instruction.
- flg0  in  1  ICU FLG0 (NOPO) flag.
- flgf  in  1  ICU FLGF (NOPF) flag.
- pc  out  PC_W  current program counter.
- depth  out  5  return-stack occupancy, 0..DEPTH.
- halted  out  1  1 while in HALT.
- stack_err  out  1  sticky stack overflow/underflow flag.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: pc=0, depth=0, call_arm=0, state=RUN, halted=0, stack_err=0, icu_en=1.
- States:
  - RUN: icu_en=1.
  - HALT: icu_en=0. pc, stack and call_arm are frozen. instr and operand still reflect rom_data.
- RUN, per rising edge, in priority order (inputs are combinational on the current word):
  1. flgf=1: pc<=pc+1; state<=HALT; call_arm<=0.
  2. jmp=1: pc<=operand.
     - If call_arm=1 and depth<DEPTH: push pc+1, depth++.
     - If call_arm=1 and depth==DEPTH: no push; stack_err<=1; jump still taken.
     - call_arm<=0.
  3. rtn=1:
     - depth>0: pc<=top of stack; depth--.
     - depth==0: pc<=0; stack_err<=1.
     - call_arm<=0.
  4. flg0=1: pc<=pc+1; call_arm<=1. A NOPO immediately preceding a JMP marks that JMP as a call.
  5. Otherwise: pc<=pc+1; call_arm<=0.
- Multiple flags asserted together (illegal from a correct ICU): the priority above resolves them; no error is flagged.
- pc+1 wraps from 2^PC_W-1 to 0. A pushed return address wraps the same way.
- HALT -> RUN on the cycle after run=1. pc resumes at the address after the NOPF.
- run=1 while in RUN is ignored.
- Reset mid-operation: all state returns to reset values immediately. Stack contents are discarded (depth=0); storage contents need not be cleared.
- stack_err clears only on rst.
- Latency: an instruction is presented in the same cycle pc points at it. Jump, call and return take effect at the next edge with no bubble.

Optional Feature:
- Macro: MC14500B_SEQ_HALT_EN.
- Defined: FLGF halt behaviour and run handling as above.
- Undefined:
  - flgf is treated as a plain instruction (rule 5).
  - State never leaves RUN; halted tied 0; icu_en tied 1; run ignored.

Test Plan (PC_W=8, DEPTH=4):
- Linear fetch: ROM of LD ops, release rst -> pc = 0,1,2,... on successive edges; 255 wraps to 0; icu_en=1 throughout.
- Plain jump: word 3 = JMP 0x40 (jmp=1, no prior NOPO) -> pc=0x40 next cycle; depth stays 0.
- Call/return:
  - NOPO at 0x10, JMP 0x80 at 0x11 -> pc=0x80, depth=1.
  - RTN at 0x85 -> pc=0x12, depth=0, stack_err=0.
- Overflow/underflow:
  - 5 nested calls -> depth saturates at 4 and stack_err=1 on the 5th; the 5th jump is still taken.
  - After reset, RTN at depth 0 -> pc=0, stack_err=1.
- Halt (macro on):
  - NOPF at 0x20 -> halted=1, icu_en=0, pc=0x21 held for 10 cycles.
  - run pulse -> RUN next cycle, pc advances to 0x22.
  - With macro off: same program never halts.
- Async reset mid-call: assert rst between clock edges with depth=2, pc=0x85 -> all outputs at reset values before the next edge.
